// File: rtl/case_eq_arbiter.sv
// Shared serial 4-state case-equality (===/!==) engine with a two-requester
// round-robin front end; compares C digits per cycle with early exit.
module case_eq_arbiter #(
  parameter int W  = 32,
  parameter int C  = 8,
  parameter int WW = $clog2(W) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [2*W-1:0]  req_a_val,
  input  logic [2*W-1:0]  req_a_xz,
  input  logic [2*W-1:0]  req_b_val,
  input  logic [2*W-1:0]  req_b_xz,
  input  logic [2*WW-1:0] req_a_w,
  input  logic [2*WW-1:0] req_b_w,
  input  logic [1:0]      req_a_s,
  input  logic [1:0]      req_b_s,
  input  logic [1:0]      req_op,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic            rsp_result
);

  localparam int NCH = W / C;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CMP = 2'd1, RESP = 2'd2} state_e;

  // Masks digits at/above the effective width and extends to W digits,
  // returning {xz, val}. Widths of 0 or above W mean a full-width operand.
  function automatic logic [2*W-1:0] extend_op(input logic [W-1:0]  v,
                                               input logic [W-1:0]  xz,
                                               input logic [WW-1:0] w,
                                               input logic          sx);
    logic [WW-1:0] ew;
    logic          mv;
    logic          mx;
    logic [W-1:0]  ov;
    logic [W-1:0]  ox;
    if ((w == {WW{1'b0}}) || (w > WW'(W))) ew = WW'(W);
    else ew = w;
    mv = 1'b0;
    mx = 1'b0;
    for (int i = 0; i < W; i++) begin
      mv = (WW'(i) == ew - WW'(1)) ? v[i]  : mv;
      mx = (WW'(i) == ew - WW'(1)) ? xz[i] : mx;
    end
    for (int i = 0; i < W; i++) begin
      if (WW'(i) < ew) begin
        ov[i] = v[i];
        ox[i] = xz[i];
      end else if (sx) begin
        ov[i] = mv;
        ox[i] = mx;
      end else begin
        ov[i] = 1'b0;
        ox[i] = 1'b0;
      end
    end
    return {ox, ov};
  endfunction

  state_e          state_q;
  logic            last_grant_q;
  logic [KW-1:0]   k_q;
  logic            id_q;
  logic            op_q;
  logic [2*W-1:0]  a_q;
  logic [2*W-1:0]  b_q;
  logic            rsp_valid_q;
  logic            rsp_id_q;
  logic            rsp_result_q;

  logic [1:0]      grant_s;
  logic            sel_s;
  logic [2*W-1:0]  a_d;
  logic [2*W-1:0]  b_d;
  logic [2*W-1:0]  diff_s;
  logic [W-1:0]    digit_ne_s;
  logic            chunk_ne_s;

  // Round-robin grant and capture-side operand extension of the winner.
  always_comb begin
    grant_s = 2'b00;
    case (req_valid)
      2'b01:   grant_s = 2'b01;
      2'b10:   grant_s = 2'b10;
      2'b11:   grant_s = last_grant_q ? 2'b01 : 2'b10;
      default: grant_s = 2'b00;
    endcase
    if (state_q == IDLE) req_ready = grant_s;
    else req_ready = 2'b00;
    sel_s = grant_s[1];
    a_d = extend_op(sel_s ? req_a_val[2*W-1:W] : req_a_val[W-1:0],
                    sel_s ? req_a_xz[2*W-1:W]  : req_a_xz[W-1:0],
                    sel_s ? req_a_w[2*WW-1:WW] : req_a_w[WW-1:0],
                    req_a_s[sel_s] & req_b_s[sel_s]);
    b_d = extend_op(sel_s ? req_b_val[2*W-1:W] : req_b_val[W-1:0],
                    sel_s ? req_b_xz[2*W-1:W]  : req_b_xz[W-1:0],
                    sel_s ? req_b_w[2*WW-1:WW] : req_b_w[WW-1:0],
                    req_a_s[sel_s] & req_b_s[sel_s]);
  end

  // Per-digit inequality of the captured operands, reduced over chunk k.
  always_comb begin
    diff_s     = a_q ^ b_q;
    digit_ne_s = diff_s[W-1:0] | diff_s[2*W-1:W];
    chunk_ne_s = |digit_ne_s[int'(k_q)*C +: C];
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      k_q          <= {KW{1'b0}};
      id_q         <= 1'b0;
      op_q         <= 1'b0;
      a_q          <= {2*W{1'b0}};
      b_q          <= {2*W{1'b0}};
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_ready) begin
            id_q         <= sel_s;
            op_q         <= req_op[sel_s];
            a_q          <= a_d;
            b_q          <= b_d;
            last_grant_q <= sel_s;
            k_q          <= {KW{1'b0}};
            state_q      <= CMP;
          end
        end
        CMP: begin
          if (chunk_ne_s) begin
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= op_q;
            rsp_id_q     <= id_q;
            state_q      <= RESP;
          end else if (k_q == KW'(NCH - 1)) begin
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= ~op_q;
            rsp_id_q     <= id_q;
            state_q      <= RESP;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;

endmodule

// File: doc/case_eq_arbiter.md
# case_eq_arbiter

Shared, serial 4-state case-equality engine (`===` / `!==`) with a two-requester round-robin arbiter. It accepts operand pairs of independent width and signedness and applies Verilog operand extension: zero-extension unless both operands are signed, sign-extension (including x/z) when both are signed. It then compares C digits per cycle with early exit on mismatch and returns a 1-bit result. The block sits beside the expression evaluator as the shared resource for all case-equality checks.

## Interface
- W, 32: maximum operand width in digits; must be a multiple of C.
- C, 8: digits compared per cycle.
- WW, $clog2(W)+1: width of the width fields.
- Digit encoding is {xz,val}: 00=0, 01=1, 10=z, 11=x.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  2  request valid; bit i is requester i.
- req_ready  out  2  request accepted on a cycle with valid&ready.
- req_a_val, req_a_xz  in  2*W  operand A digits; requester i is slice [i*W +: W].
- req_b_val, req_b_xz  in  2*W  operand B digits, same layout.
- req_a_w, req_b_w  in  2*WW  operand widths in digits.
- req_a_s, req_b_s  in  2  operand signed flags.
- req_op  in  2  0 = `===`, 1 = `!==`.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  1  requester that issued the response.
- rsp_result  out  1  comparison result.

## Operation
- States: IDLE, CMP, RESP.
- Reset to IDLE. Reset values: rsp_valid=0, rsp_id=0, rsp_result=0, req_ready=00. Internal last_grant resets to 1, so requester 0 wins first.
- IDLE, arbitration:
  - req_ready is a one-hot grant, combinational from req_valid and last_grant.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester not equal to last_grant is granted.
  - On accept: capture that requester's fields, set last_grant, set chunk index k=0, go to CMP.
- req_ready=00 in CMP and RESP. Requests are never accepted outside IDLE.
- Width fields: a value of 0 or greater than W is treated as W.
- Masking: digits at or above an operand's width are ignored.
- Extension, applied to both operands to W digits:
  - If both signed flags are 1: replicate the MSB digit (x/z replicate as x/z).
  - Otherwise: fill with 0 (digit 00).
- Digit match: exact equality of {xz,val}. x matches only x, z matches only z.
- CMP cycle k:
  - Compare extended digits [k*C +: C].
  - Any mismatch: match=0, go to RESP (early exit).
  - Else if k=W/C-1: match=1, go to RESP.
  - Else k=k+1.
- Entering RESP: rsp_valid=1, rsp_result = match XOR op, rsp_id = captured requester.
- RESP: outputs hold stable until rsp_valid&rsp_ready. Then rsp_valid=0 and state returns to IDLE.

## Timing
- Accept at edge E0. Chunk k is evaluated in the cycle after edge E(k). rsp_valid is high after edge En, where n is the number of chunks compared.
  - Full match: n=W/C (4 with defaults).
  - Mismatch in chunk j: n=j+1.
- Response handshake at edge Er: rsp_valid=0 after Er. The earliest next accept is at edge Er+1 (one IDLE cycle). Throughput is at most one compare per n+2 cycles.
- Response is registered. No combinational path from rsp_ready to any output; req_ready depends on state and req_valid only.
- rst=1 at any edge, including mid-CMP or in RESP, discards the in-flight compare. After that edge: rsp_valid=0, last_grant=1, state IDLE. No response is emitted for the discarded request.
- Input fields must be stable only in the accept cycle.

## Test plan
- Basic compare, requester 0: 8'd10 vs 8'd10, op 0 -> rsp_result=1, rsp_id=0, rsp_valid 4 cycles after accept. 8'd10 vs 8'd20, op 1 -> 1. 8'd10 vs 8'd10, op 1 -> 0.
- X/Z: 1'bx vs 1'bx -> 1; 1'bz vs 1'bz -> 1; 1'bx vs 1'bz -> 0; 1'bx vs 1'b1 -> 0; 1'bz vs 1'b1 with op 1 -> 1.
- Extension:
  - 1'b1 vs 2'b01 -> 1.
  - 3'sb111 vs 2'sb11 -> 1 (sign extension).
  - 3'b111 vs 2'sb11 -> 0 (mixed signedness, zero extension).
  - 1'sbx vs 4'sbxxxx -> 1.
  - 1'bx vs 4'bxxxx -> 0.
  - Bits above the width set to garbage -> result unchanged.
- Early exit: 32'h0000_0001 vs 0 -> rsp_valid 1 cycle after accept. 32'h0100_0000 vs 0 -> 4 cycles. Both give result 0.
- Arbitration and backpressure:
  - Both req_valid high continuously after reset -> ids 0,1,0,1.
  - Hold rsp_ready low 5 cycles -> rsp_valid, rsp_id, rsp_result stable and req_ready=00 throughout.
- Reset mid-CMP (chunk 2) -> rsp_valid=0 next cycle, no response. With both valid after reset, requester 0 is granted first.
